fetch_prefetch_unit: RTL

//  Parametrised instruction-fetch stage with an in-order prefetch buffer. Issues pipelined

---
 rtl/fetch_prefetch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage with an in-order prefetch buffer.
// Pipelined word requests go to imem. Returned {pc, instruction} pairs are queued and handed
// to decode through a valid/ready handshake. A redirect flushes the queue and discards any
// response still outstanding.
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            request,
    output logic [XLEN-1:0] address_out,
    output logic [3:0]      mask,
    output logic            we_re,
    input  logic            valid,
    input  logic [XLEN-1:0] instruction_fetch,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pre_address_pc
);

    localparam int unsigned     PtrW    = $clog2(DEPTH);
    localparam int unsigned     CntW    = PtrW + 1;
    localparam logic [CntW:0]   DepthC  = (CntW + 1)'(DEPTH);
    localparam logic [CntW-1:0] MaxOutC = CntW'(MAX_OUT);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] inflight_q, inflight_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] ins_mem [DEPTH];

    logic            issue;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] target_pc;

    // Low address bits of a redirect target are forced to zero.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^redirect_addr[1:0];
    assign target_pc        = {redirect_addr[XLEN-1:2], 2'b00};

    // Issue credit counts both buffered and in-flight words, so every response has a slot.
    always_comb begin
        issue = !rst && !redirect && (inflight_q < MaxOutC) &&
                (({1'b0, count_q} + {1'b0, inflight_q}) < DepthC);
        push  = valid && (drop_q == '0) && !redirect;
        pop   = inst_valid && inst_ready && !redirect;
    end

    // Next-state for fetch/response PCs, occupancy, credits and stale-response drops.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = inflight_q + CntW'(issue) - CntW'(valid);
        if (redirect) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // inflight_q already includes pending drops: every outstanding response
            // becomes stale, minus the one consumed this cycle.
            drop_d     = inflight_q - CntW'(valid);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
            if (valid && (drop_q != '0)) begin
                drop_d = drop_q - CntW'(1);
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Buffer storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= resp_pc_q;
            ins_mem[wr_ptr_q] <= instruction_fetch;
        end
    end

    // Outputs: imem request fields and the buffer head.
    always_comb begin
        request        = issue;
        address_out    = fetch_pc_q;
        mask           = 4'b1111;
        we_re          = 1'b0;
        inst_valid     = !rst && (count_q != '0);
        instruction    = ins_mem[rd_ptr_q];
        pc_out         = pc_mem[rd_ptr_q];
        pre_address_pc = pc_mem[rd_ptr_q] + XLEN'(4);
    end

endmodule
